la_clkgate_ctrl: RTL and testbench
==================================

LA_CLKGATE_CTRL -- requirements
Module: la_clkgate_ctrl

Interface
REQ-001 Parameter PROP, default "DEFAULT": implementation property string, passed through to sub-modules.
REQ-002 Parameter N, default 4: number of gated channels, 2..32.
REQ-003 Parameter IDLEW, default 4: idle counter width, 1..16.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 req  input  N  per-channel activity request; level-sensitive.
REQ-007 idle_limit  input  IDLEW  shared cool-down length in cycles; sampled every cycle.
REQ-008 en  output  N  registered gate enable, ANDed with the channel clock downstream.
REQ-009 ack  output  N  registered per-channel indication that the clock is running and settled.

Function
REQ-010 Each channel SHALL run its own FSM with states OFF, WAKE, ON and COOL.
REQ-011 Outputs SHALL decode from state: en=1 in WAKE, ON and COOL; ack=1 in ON and COOL; both are 0 in OFF.
REQ-012 OFF->WAKE SHALL occur only when the channel is granted; at most one grant SHALL issue per cycle (inrush limit).
REQ-013 Grant: round-robin among channels in OFF with req=1; pick the lowest index >= ptr, wrapping modulo N; then ptr<=grant+1 mod N; ptr SHALL stay unchanged when there is no grant.
REQ-014 WAKE->ON SHALL occur unconditionally after 1 cycle; the req level during WAKE is ignored.
REQ-015 In ON: req=0 -> COOL with cnt<=0; req=1 -> stay ON.
REQ-016 In COOL: req=1 -> ON, and this takes priority over expiry in the same cycle; else cnt>=idle_limit -> OFF; else cnt<=cnt+1.
REQ-017 Latency: req rises at cycle t with an immediate grant -> en=1 at t+1, ack=1 at t+2.
REQ-018 Latency: req falls at cycle t in ON with no re-request -> en=0 and ack=0 at t+idle_limit+2.
REQ-019 idle_limit=0 -> COOL SHALL last exactly 1 cycle.
REQ-020 A reduction of idle_limit below cnt mid-cool SHALL cause OFF on the next evaluation (>= compare).
REQ-021 cnt SHALL never wrap; its maximum is 2^IDLEW-1.
REQ-022 A channel waiting for a grant SHALL keep en=0 and SHALL be granted within N cycles.

Reset
REQ-023 While reset=1, all FSMs SHALL be OFF, cnt=0, ptr=0, en=0 and ack=0 at the next edge, regardless of req.
REQ-024 reset asserted mid-operation (WAKE/ON/COOL) SHALL force en=0 and ack=0 one cycle later, with no cool-down.
REQ-025 After reset release, normal arbitration SHALL resume on the first edge, starting from ptr=0.

Configuration
REQ-026 Macro LA_CLKGATE_CTRL_FORCE_EN defined: add input force_on (1 bit); force_on=1 SHALL drive en to all ones combinationally over the registered value; ack, FSMs and arbitration SHALL be unaffected.
REQ-027 Macro undefined: the force_on port SHALL be absent and behaviour SHALL be identical to force_on=0.

Structure
REQ-028 Package la_clkgate_ctrl_pkg SHALL hold the state encoding localparams (OFF, WAKE, ON, COOL; 2 bits).
REQ-029 The per-channel FSM plus counter SHALL be sub-module la_clkgate_chan, instanced N times via generate.
REQ-030 The round-robin arbiter and ptr SHALL live in the top module.

Verification (N=4, IDLEW=4)
REQ-031 Reset: reset=1 for 3 cycles with req=4'hF -> en=0 and ack=0 during reset and on the first cycle after release; ch0 en=1 on the second cycle after release.
REQ-032 Single channel: idle_limit=3; req[2] rises at cycle 10 and falls at cycle 20 -> en[2]=1 at 11, ack[2]=1 at 12, en[2]=0 and ack[2]=0 at 25.
REQ-033 Contention: req=4'hF from all-OFF with ptr=0 -> en becomes 0001, 0011, 0111, 1111 on consecutive cycles; ptr ends at 0.
REQ-034 Cool rescue: idle_limit=5; req[1] low for 2 cycles, then high -> en[1] and ack[1] never drop; COOL->ON transition observed.
REQ-035 Mid-op reset: reset pulsed while ch3 is in WAKE and ch0 is in COOL -> next cycle en=0 and ack=0; a later req[1] is granted first.
REQ-036 Force (macro defined): force_on=1 with req=0 -> en=4'hF and ack=0; dropping force_on -> en=0 the same cycle.

Source files
------------

// File: rtl/la_clkgate_ctrl_pkg.sv
// Shared state encoding for the clock-gate controller channels.
package la_clkgate_ctrl_pkg;

  localparam logic [1:0] ST_OFF  = 2'd0;
  localparam logic [1:0] ST_WAKE = 2'd1;
  localparam logic [1:0] ST_ON   = 2'd2;
  localparam logic [1:0] ST_COOL = 2'd3;

  typedef enum logic [1:0] {
    CS_OFF  = ST_OFF,
    CS_WAKE = ST_WAKE,
    CS_ON   = ST_ON,
    CS_COOL = ST_COOL
  } chan_state_e;

endpackage

// File: rtl/la_clkgate_chan.sv
// One gated-clock channel: OFF/WAKE/ON/COOL FSM with a saturating cool-down counter.
// State is exported on o_state so checkers can bind to it directly.
module la_clkgate_chan
  import la_clkgate_ctrl_pkg::*;
#(
  parameter string PROP  = "DEFAULT",
  parameter int    IDLEW = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_grant,
  input  logic             i_req,
  input  logic [IDLEW-1:0] i_idle_limit,
  output logic             o_en,
  output logic             o_ack,
  output logic             o_waiting,
  output chan_state_e      o_state
);

  localparam logic [IDLEW-1:0] CNT_ONE = 1;
  localparam logic [IDLEW-1:0] CNT_MAX = '1;

  if (PROP == "") begin : g_bad_prop
    $error("la_clkgate_chan: PROP must not be empty");
  end

  chan_state_e      r_state;
  chan_state_e      w_state_nx;
  logic [IDLEW-1:0] r_cnt;
  logic [IDLEW-1:0] w_cnt_nx;
  logic             r_en;
  logic             r_ack;

  // COOL: a returning request beats expiry; expiry uses >= so a shrunk limit ends cool-down at once.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    unique case (r_state)
      CS_OFF:  if (i_grant) w_state_nx = CS_WAKE;
      CS_WAKE: w_state_nx = CS_ON;
      CS_ON: begin
        if (!i_req) begin
          w_state_nx = CS_COOL;
          w_cnt_nx   = '0;
        end
      end
      CS_COOL: begin
        if (i_req) begin
          w_state_nx = CS_ON;
        end else if (r_cnt >= i_idle_limit) begin
          w_state_nx = CS_OFF;
          w_cnt_nx   = '0;
        end else if (r_cnt != CNT_MAX) begin
          w_cnt_nx = r_cnt + CNT_ONE;
        end
      end
      default: w_state_nx = CS_OFF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= CS_OFF;
      r_cnt   <= '0;
      r_en    <= 1'b0;
      r_ack   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_en    <= (w_state_nx != CS_OFF);
      r_ack   <= (w_state_nx == CS_ON) || (w_state_nx == CS_COOL);
    end
  end

  assign o_en      = r_en;
  assign o_ack     = r_ack;
  assign o_state   = r_state;
  assign o_waiting = (r_state == CS_OFF) && i_req;

endmodule

// File: rtl/la_clkgate_ctrl.sv
// Clock-gate controller: N channel FSMs plus a round-robin wake arbiter (one wake per cycle).
// Optional macro LA_CLKGATE_CTRL_FORCE_EN adds force_on, which ORs all ones into en.
module la_clkgate_ctrl
  import la_clkgate_ctrl_pkg::*;
#(
  parameter string PROP  = "DEFAULT",
  parameter int    N     = 4,
  parameter int    IDLEW = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     req,
  input  logic [IDLEW-1:0] idle_limit,
  output logic [N-1:0]     en,
  output logic [N-1:0]     ack
`ifdef LA_CLKGATE_CTRL_FORCE_EN
  ,
  input  logic             force_on
`endif
);

  localparam int PTRW = (N > 1) ? $clog2(N) : 1;

  if (N < 2 || N > 32 || IDLEW < 1 || IDLEW > 16) begin : g_bad_param
    $error("la_clkgate_ctrl: N must be 2..32 and IDLEW 1..16");
  end

  logic [PTRW-1:0] r_ptr;
  logic [PTRW-1:0] w_gidx;
  logic [PTRW-1:0] w_ptr_nx;
  logic            w_found;
  int              w_idx;
  logic [N-1:0]    w_waiting;
  logic [N-1:0]    w_grant;
  logic [N-1:0]    w_en_reg;
  chan_state_e     w_state [N];

  // Descending scan so the last hit, i.e. the nearest index at or after r_ptr, wins.
  always_comb begin
    w_found = 1'b0;
    w_gidx  = '0;
    w_idx   = 0;
    for (int k = N - 1; k >= 0; k--) begin
      w_idx = int'(r_ptr) + k;
      if (w_idx >= N) w_idx = w_idx - N;
      if (w_waiting[w_idx]) begin
        w_found = 1'b1;
        w_gidx  = PTRW'(w_idx);
      end
    end
  end

  always_comb begin
    w_grant = '0;
    if (w_found) w_grant[w_gidx] = 1'b1;
  end

  assign w_ptr_nx = (int'(w_gidx) == N - 1) ? '0 : w_gidx + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr <= '0;
    end else if (w_found) begin
      r_ptr <= w_ptr_nx;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_chan
    la_clkgate_chan #(
      .PROP  (PROP),
      .IDLEW (IDLEW)
    ) u_chan (
      .clk          (clk),
      .reset        (reset),
      .i_grant      (w_grant[i]),
      .i_req        (req[i]),
      .i_idle_limit (idle_limit),
      .o_en         (w_en_reg[i]),
      .o_ack        (ack[i]),
      .o_waiting    (w_waiting[i]),
      .o_state      (w_state[i])
    );
  end

`ifdef LA_CLKGATE_CTRL_FORCE_EN
  assign en = w_en_reg | {N{force_on}};
`else
  assign en = w_en_reg;
`endif

endmodule

// File: tb/tb_la_clkgate_ctrl.sv
// Directed bench for la_clkgate_ctrl (N=4, IDLEW=4) with immediate-assertion checks.
module tb_la_clkgate_ctrl;
  import la_clkgate_ctrl_pkg::*;

  localparam int N     = 4;
  localparam int IDLEW = 4;

  logic             clk;
  logic             reset;
  logic [N-1:0]     req;
  logic [IDLEW-1:0] idle_limit;
  logic [N-1:0]     en;
  logic [N-1:0]     ack;
`ifdef LA_CLKGATE_CTRL_FORCE_EN
  logic             force_on;
`endif

  int errors = 0;
  int checks = 0;

  la_clkgate_ctrl #(
    .PROP  ("DEFAULT"),
    .N     (N),
    .IDLEW (IDLEW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .idle_limit (idle_limit),
    .en         (en),
    .ack        (ack)
`ifdef LA_CLKGATE_CTRL_FORCE_EN
    ,
    .force_on   (force_on)
`endif
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_io(input string tag, input logic [N-1:0] exp_en, input logic [N-1:0] exp_ack);
    check({tag, ".en"}, 32'(en), 32'(exp_en));
    check({tag, ".ack"}, 32'(ack), 32'(exp_ack));
  endtask

  initial begin
    reset      = 1'b1;
    req        = 4'hF;
    idle_limit = 4'd3;
`ifdef LA_CLKGATE_CTRL_FORCE_EN
    force_on   = 1'b0;
`endif

    // reset held three cycles with all requests high
    tick(); check_io("rst_c1", 4'h0, 4'h0);
    tick(); check_io("rst_c2", 4'h0, 4'h0);
    tick(); check_io("rst_c3", 4'h0, 4'h0);
    reset = 1'b0;
    #1 check_io("rel_c1", 4'h0, 4'h0);

    // contention: one wake per cycle, in index order from ptr=0
    tick(); check_io("cont1", 4'b0001, 4'b0000);
    tick(); check_io("cont2", 4'b0011, 4'b0001);
    tick(); check_io("cont3", 4'b0111, 4'b0011);
    tick(); check_io("cont4", 4'b1111, 4'b0111);
    check("cont_ptr", 32'(dut.r_ptr), 32'd0);
    tick(); check_io("cont5", 4'b1111, 4'b1111);

    // all drop with idle_limit=3: off after idle_limit+2 cycles
    req = 4'h0;
    for (int i = 0; i < 4; i++) begin
      tick(); check_io("cool_all", 4'hF, 4'hF);
    end
    tick(); check_io("cool_all_off", 4'h0, 4'h0);

    // single channel 2: rise at t, fall at t+10
    req = 4'b0100;
    tick(); check_io("ch2_wake", 4'b0100, 4'b0000);
    check("ch2_state_wake", 32'(dut.g_chan[2].u_chan.o_state), 32'(ST_WAKE));
    tick(); check_io("ch2_on", 4'b0100, 4'b0100);
    for (int i = 0; i < 8; i++) tick();
    req = 4'b0000;
    for (int i = 0; i < 4; i++) tick();
    check_io("ch2_cool_end", 4'b0100, 4'b0100);
    tick(); check_io("ch2_off", 4'b0000, 4'b0000);
    check("ch2_ptr", 32'(dut.r_ptr), 32'd3);

    // wrap: ptr=3, ch3 idle, so ch0 then ch1
    req = 4'b0011;
    tick(); check_io("wrap1", 4'b0001, 4'b0000);
    tick(); check_io("wrap2", 4'b0011, 4'b0001);
    tick(); check_io("wrap3", 4'b0011, 4'b0011);

    // cool rescue on ch1 with idle_limit=5
    idle_limit = 4'd5;
    req = 4'b0001;
    tick(); check_io("resc1", 4'b0011, 4'b0011);
    check("resc_cool", 32'(dut.g_chan[1].u_chan.o_state), 32'(ST_COOL));
    tick(); check_io("resc2", 4'b0011, 4'b0011);
    req = 4'b0011;
    tick(); check_io("resc3", 4'b0011, 4'b0011);
    check("resc_on", 32'(dut.g_chan[1].u_chan.o_state), 32'(ST_ON));

    // idle_limit=0: COOL lasts exactly one cycle
    idle_limit = 4'd0;
    req = 4'b0000;
    tick(); check_io("lim0_cool", 4'b0011, 4'b0011);
    tick(); check_io("lim0_off", 4'b0000, 4'b0000);

    // shrinking idle_limit below cnt ends cool-down on the next edge (ptr=2 -> ch2)
    idle_limit = 4'd8;
    req = 4'b0100;
    tick(); tick(); check_io("shr_on", 4'b0100, 4'b0100);
    req = 4'b0000;
    for (int i = 0; i < 5; i++) tick();
    check("shr_cnt", 32'(dut.g_chan[2].u_chan.r_cnt), 32'd4);
    check_io("shr_cool", 4'b0100, 4'b0100);
    idle_limit = 4'd2;
    tick(); check_io("shr_off", 4'b0000, 4'b0000);

    // mid-op reset with ch0 in COOL and ch3 in WAKE (ptr=3 -> ch0 first)
    idle_limit = 4'd5;
    req = 4'b0001;
    tick(); tick(); check_io("mid_ch0", 4'b0001, 4'b0001);
    req = 4'b1000;
    tick();
    check("mid_ch3_wake", 32'(dut.g_chan[3].u_chan.o_state), 32'(ST_WAKE));
    check("mid_ch0_cool", 32'(dut.g_chan[0].u_chan.o_state), 32'(ST_COOL));
    reset = 1'b1;
    tick(); check_io("mid_rst", 4'b0000, 4'b0000);
    check("mid_rst_ptr", 32'(dut.r_ptr), 32'd0);
    reset = 1'b0;
    req = 4'b1010;
    tick(); check_io("post_rst1", 4'b0010, 4'b0000);
    tick(); check_io("post_rst2", 4'b1010, 4'b0010);

`ifdef LA_CLKGATE_CTRL_FORCE_EN
    // force overrides en combinationally; ack untouched
    reset = 1'b1;
    req = 4'b0000;
    tick();
    reset = 1'b0;
    tick(); check_io("frc_idle", 4'h0, 4'h0);
    force_on = 1'b1;
    #1 check_io("frc_on", 4'hF, 4'h0);
    tick(); check_io("frc_hold", 4'hF, 4'h0);
    force_on = 1'b0;
    #1 check_io("frc_off", 4'h0, 4'h0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
